ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the EX-stage operands, funct3 and M-extension enable driven by the ID/EX pipeline register, after forwarding.
- Holds the pipeline with a stall while it computes, then presents a single-cycle valid result for the EX result mux and the EX/MEM register.
- Radix-2, one bit per cycle; special divide cases resolve in one cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the counter is 5 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- ex_md_en  input  1  the instruction in EX is an M-extension op (opcode R-type, funct7=0000001).
- ex_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_op_a  input  XLEN  rs1 operand, post-forwarding.
- ex_op_b  input  XLEN  rs2 operand, post-forwarding.
- ex_flush  input  1  kill the instruction in EX (taken branch/jump redirect).
- md_result  output  XLEN  registered result.
- md_valid  output  1  result valid this cycle; pulses for one cycle.
- md_stall  output  1  combinational stall request to the hazard unit; freezes PC, IF/ID and ID/EX.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, counter=0, md_result=0, md_valid=0. md_stall=0 in IDLE with ex_md_en=0.
- States: IDLE, CALC, DONE.
- IDLE, ex_md_en=1, ex_flush=0:
  - Latch funct3 and the operand magnitudes, plus the result-sign flag.
  - Signed ops negate negative operands. MULHSU treats only op_a as signed.
  - Special divide cases go straight to DONE with md_result loaded:
    - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
    - DIV with op_a=0x80000000, op_b=0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - All other cases: counter=31, go to CALC.
- CALC, multiply:
  - 64-bit accumulator, shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder; subtract and compare unsigned.
- CALC, every cycle: decrement the counter. When the counter=0 this cycle, apply the sign fix-up and select the result, register md_result, go to DONE.
  - CALC therefore lasts exactly 32 cycles.
- Result select:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32], computed from the signed-corrected 64-bit product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign fix-up:
  - Multiply: negate the product if the sign flag is set.
  - Quotient: negate if the dividend and divisor signs differ.
  - Remainder: takes the dividend's sign.
- DONE: md_valid=1, md_stall=0; the pipeline advances this cycle. Next state is IDLE unconditionally.
  - A following M-op is seen in IDLE on the next cycle and starts a new operation. Back-to-back ops are therefore supported.
- md_stall = ex_md_en & ~ex_flush & (state != DONE).
  - Normal op first seen at cycle T (IDLE): stall high T..T+32, md_valid high at T+33.
  - Special case: stall high at T only; md_valid high at T+1.
- Operands and funct3 are latched at start. Input changes during CALC are ignored.
- ex_flush (priority below rst):
  - In any state, next state=IDLE and md_valid=0 next cycle.
  - md_result is not updated.
  - md_stall=0 in the flush cycle.
- rst mid-operation: next cycle IDLE, md_result=0, md_valid=0. No stale md_valid afterwards.
- ex_md_en=0 in IDLE: no action; md_result holds its last value.
- md_result holds its value outside DONE. Consumers qualify it with md_valid only.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), ex_md_en held from T:
  - md_stall=1 for T..T+32.
  - At T+33: md_valid=1, md_result=0xFFFFFFEB, md_stall=0.
- Upper-half multiplies on 0x80000000 × 0x80000000:
  - MULH gives 0x40000000 and MULHU gives 0x40000000.
  - MULHSU with op_a=0xFFFFFFFF, op_b=0xFFFFFFFF gives 0xFFFFFFFF.
- Signed divide, op_a=0xFFFFFFF9 (−7), op_b=2:
  - DIV gives 0xFFFFFFFD.
  - REM gives 0xFFFFFFFF.
  - Back to back: the second op starts the cycle after the first md_valid, and its md_valid arrives 34 cycles later.
- Special cases:
  - DIVU 0x1234/0 gives 0xFFFFFFFF.
  - REMU 0x1234/0 gives 0x00001234.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM on the same operands gives 0.
  - Each with stall for exactly 1 cycle and md_valid at T+1.
- Flush: DIV started at T, ex_flush=1 at T+10:
  - md_stall=0 at T+10, state IDLE at T+11.
  - No md_valid pulse follows; md_result is unchanged.
- Reset: rst=1 at T+20 of a MUL:
  - At T+21: md_result=0, md_valid=0.
  - With ex_md_en=0, md_stall stays 0 and no valid pulse follows.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the ID/EX pipeline stage and the iterative
// M-extension unit. The pipeline side drives the ex_* signals; the unit drives md_*.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            ex_md_en;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_op_a;
    logic [XLEN-1:0] ex_op_b;
    logic            ex_flush;
    logic [XLEN-1:0] md_result;
    logic            md_valid;
    logic            md_stall;

    modport master (
        output ex_md_en, ex_funct3, ex_op_a, ex_op_b, ex_flush,
        input  md_result, md_valid, md_stall
    );

    modport slave (
        input  ex_md_en, ex_funct3, ex_op_a, ex_op_b, ex_flush,
        output md_result, md_valid, md_stall
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage: 32 cycles of
// shift-add or restoring division, one-cycle special divide cases, stall while busy.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] hi_q, hi_d;    // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;    // multiplier bits / dividend-then-quotient
    logic [XLEN-1:0] opb_q, opb_d;  // multiplicand / divisor magnitude
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode for the instruction currently presented in EX
    logic            a_signed, b_signed, sign_a, sign_b, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed = bus.ex_funct3[2] ? ~bus.ex_funct3[0] : (bus.ex_funct3 != 3'b011);
        b_signed = bus.ex_funct3[2] ? ~bus.ex_funct3[0] : ~bus.ex_funct3[1];
        sign_a   = a_signed & bus.ex_op_a[XLEN-1];
        sign_b   = b_signed & bus.ex_op_b[XLEN-1];
        a_mag    = sign_a ? ({XLEN{1'b0}} - bus.ex_op_a) : bus.ex_op_a;
        b_mag    = sign_b ? ({XLEN{1'b0}} - bus.ex_op_b) : bus.ex_op_b;
        // Remainder follows the dividend; everything else follows the XOR of signs
        neg_in   = (bus.ex_funct3[2] & bus.ex_funct3[1]) ? sign_a : (sign_a ^ sign_b);
        b_zero   = (bus.ex_op_b == {XLEN{1'b0}});
        div_ovf  = ~bus.ex_funct3[0] & (bus.ex_op_a == INT_MIN) & (bus.ex_op_b == {XLEN{1'b1}});
        special  = bus.ex_funct3[2] & (b_zero | div_ovf);
        if (b_zero)
            special_res = bus.ex_funct3[1] ? bus.ex_op_a : {XLEN{1'b1}};
        else
            special_res = bus.ex_funct3[1] ? {XLEN{1'b0}} : INT_MIN;
    end

    // One iteration of the datapath, shared by multiply and divide
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_sub;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_sub   = {1'b0, div_shift[XLEN-1:0]} - {1'b0, opb_q};
        // A set top bit already exceeds any 32-bit divisor; otherwise no borrow means >=
        div_ge    = div_shift[XLEN] | ~div_sub[XLEN];
        if (f3_q[2]) begin
            step_hi = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? ({(2*XLEN){1'b0}} - {step_hi, step_lo}) : {step_hi, step_lo};
        quo_fix  = neg_q ? ({XLEN{1'b0}} - step_lo) : step_lo;
        rem_fix  = neg_q ? ({XLEN{1'b0}} - step_hi) : step_hi;
        case (f3_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        if (bus.ex_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ex_md_en) begin
                        f3_d  = bus.ex_funct3;
                        neg_d = neg_in;
                        hi_d  = {XLEN{1'b0}};
                        lo_d  = bus.ex_funct3[2] ? a_mag : b_mag;
                        opb_d = bus.ex_funct3[2] ? b_mag : a_mag;
                        if (special) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            cnt_d   = 5'd31;
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        result_d = fix_val;
                        state_d  = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            f3_q     <= 3'b000;
            neg_q    <= 1'b0;
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            opb_q    <= {XLEN{1'b0}};
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign bus.md_result = result_q;
    assign bus.md_valid  = (state_q == S_DONE);
    assign bus.md_stall  = bus.ex_md_en & ~bus.ex_flush & (state_q != S_DONE);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, and flush/reset/back-to-back sequences.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.XLEN(32)) bus();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res = 32'h0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic with the RISC-V divide rules
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] up;
        int          qa, qb;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(qa / qb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(qa % qb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Starts an op at the current negedge and follows it to its valid pulse.
    // b2b: called from the previous op's DONE cycle, so one extra cycle elapses.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit b2b,
                          input bit keep, input string nm);
        int  want;
        bit  found;
        want  = b2b ? lat + 1 : lat;
        found = 1'b0;
        bus.ex_md_en  = 1'b1;
        bus.ex_funct3 = f3;
        bus.ex_op_a   = a;
        bus.ex_op_b   = b;
        #1;
        check({nm, ".stall_start"}, {31'b0, bus.md_stall}, b2b ? 32'd0 : 32'd1);
        for (int k = 1; k <= 45 && !found; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) begin
                bus.ex_funct3 = 3'($urandom_range(0, 7));
                bus.ex_op_a   = $urandom;
                bus.ex_op_b   = $urandom;
            end
            if (bus.md_valid) begin
                found = 1'b1;
                check({nm, ".latency"}, k, want);
                check({nm, ".result"}, bus.md_result, exp);
                check({nm, ".stall_done"}, {31'b0, bus.md_stall}, 32'd0);
                $display("op %s f3=%0d a=%h b=%h result=%h cycles=%0d", nm, f3, a, b,
                         bus.md_result, k);
            end else begin
                check({nm, ".stall_busy"}, {31'b0, bus.md_stall}, 32'd1);
            end
        end
        if (!found) check({nm, ".valid_timeout"}, 32'd0, 32'd1);
        last_res = exp;
        if (!keep) begin
            bus.ex_md_en = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check({nm, ".valid_pulse"}, {31'b0, bus.md_valid}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        bit          seen;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[7]  = '{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
        vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[10] = '{3'd4, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        vecs[11] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[12] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555, 33};
        vecs[13] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
        vecs[14] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};

        rst           = 1'b1;
        bus.ex_md_en  = 1'b0;
        bus.ex_funct3 = 3'd0;
        bus.ex_op_a   = 32'h0;
        bus.ex_op_b   = 32'h0;
        bus.ex_flush  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.result", bus.md_result, 32'h0);
        check("reset.valid", {31'b0, bus.md_valid}, 32'd0);
        check("reset.stall", {31'b0, bus.md_stall}, 32'd0);

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0, 1'b0,
                   $sformatf("vec%0d", i));

        // Back to back: DIV then REM, second starts in the first op's DONE cycle
        run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, 1'b0, 1'b1, "b2b_div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, 1'b1, 1'b0, "b2b_rem");

        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op(rf3, ra, rb, ref_result(rf3, ra, rb), ref_latency(rf3, ra, rb), 1'b0,
                   1'b0, $sformatf("rand%0d", i));
        end

        // Flush a DIV at T+10
        bus.ex_md_en  = 1'b1;
        bus.ex_funct3 = 3'd4;
        bus.ex_op_a   = 32'd100;
        bus.ex_op_b   = 32'd7;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.ex_flush = 1'b1;
        #1;
        check("flush.stall", {31'b0, bus.md_stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.ex_flush = 1'b0;
        bus.ex_md_en = 1'b0;
        #1;
        check("flush.valid_next", {31'b0, bus.md_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.md_valid) seen = 1'b1;
        end
        check("flush.no_valid", {31'b0, seen}, 32'd0);
        check("flush.result_held", bus.md_result, last_res);
        $display("op flush_div result=%h", bus.md_result);
        run_op(3'd0, 32'd6, 32'd7, 32'd42, 33, 1'b0, 1'b0, "after_flush");

        // Reset in the middle of a MUL at T+20
        bus.ex_md_en  = 1'b1;
        bus.ex_funct3 = 3'd0;
        bus.ex_op_a   = 32'h1234_5678;
        bus.ex_op_b   = 32'h0000_0003;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst          = 1'b1;
        bus.ex_md_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.result", bus.md_result, 32'h0);
        check("rst_mid.valid", {31'b0, bus.md_valid}, 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.md_valid || bus.md_stall) seen = 1'b1;
        end
        check("rst_mid.quiet", {31'b0, seen}, 32'd0);
        $display("op reset_mid_mul result=%h", bus.md_result);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
